up_down_counter: RTL and testbench



---
 rtl/up_down_pkg.sv | 10 +
 rtl/up_down_counter_if.sv | 10 +
 rtl/up_down_counter.sv | 72 +++++++
 tb/tb_up_down_counter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/up_down_pkg.sv
// Shared types and default sizing for the bounce counter.
package up_down_pkg;

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   localparam int CNT_WIDTH_DEF = 5;
   localparam int CNT_MIN_DEF   = 0;
   localparam int CNT_MAX_DEF   = 31;

endpackage

// File: rtl/up_down_counter_if.sv
// Enable/count bundle between a controller (master) and the counter (slave).
interface up_down_counter_if #(
   parameter int WIDTH = 5
);
   logic             enable;
   logic [WIDTH-1:0] count;

   modport master (output enable, input  count);
   modport slave  (input  enable, output count);
endinterface

// File: rtl/up_down_counter.sv
// Bidirectional triangle counter: sweeps CNT_MIN..CNT_MAX..CNT_MIN while enabled,
// presenting each endpoint for exactly one enabled cycle.
module up_down_counter
   import up_down_pkg::*;
#(
   parameter int WIDTH   = CNT_WIDTH_DEF,
   parameter int CNT_MIN = CNT_MIN_DEF,
   parameter int CNT_MAX = CNT_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   up_down_counter_if.slave  bus
);

   generate
      if (CNT_MIN < 0 || CNT_MIN >= CNT_MAX || (CNT_MAX >> WIDTH) != 0) begin : g_bad_params
         $error("up_down_counter: need 0 <= CNT_MIN < CNT_MAX <= 2**WIDTH-1");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(CNT_MIN);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(CNT_MAX);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;
   dir_t             dir_q, dir_d;

   // Endpoint tests use >= / <= so an out-of-range value is clamped back
   // into the window instead of wrapping.
   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      if (bus.enable) begin
         if (dir_q == DIR_UP) begin
            if (count_q >= MAX_V) begin
               if (count_q == MAX_V) begin
                  count_d = MAX_V - ONE;
                  dir_d   = DIR_DOWN;
               end else begin
                  count_d = MAX_V;
               end
            end else begin
               count_d = count_q + ONE;
            end
         end else begin
            if (count_q <= MIN_V) begin
               if (count_q == MIN_V) begin
                  count_d = MIN_V + ONE;
                  dir_d   = DIR_UP;
               end else begin
                  count_d = MIN_V;
               end
            end else begin
               count_d = count_q - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= MIN_V;
         dir_q   <= DIR_UP;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
      end
   end

   assign bus.count = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboard bench for up_down_counter: default 0..31 instance plus a 3..6 instance.
module tb_up_down_counter;

   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;

   always #5 clk = ~clk;

   up_down_counter_if #(.WIDTH(5)) bus_a ();
   up_down_counter_if #(.WIDTH(4)) bus_b ();

   up_down_counter #(.WIDTH(5), .CNT_MIN(0), .CNT_MAX(31)) dut_a (
      .clk   (clk),
      .reset (reset_a),
      .bus   (bus_a.slave)
   );

   up_down_counter #(.WIDTH(4), .CNT_MIN(3), .CNT_MAX(6)) dut_b (
      .clk   (clk),
      .reset (reset_b),
      .bus   (bus_b.slave)
   );

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];

   // reference model state
   int ma_c = 0;
   bit ma_d = 1'b0;
   int mb_c = 3;
   bit mb_d = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_next(input int lo, input int hi,
                                      inout int c, inout bit d);
      if (!d) begin
         if (c < hi) c = c + 1;
         else begin c = hi - 1; d = 1'b1; end
      end else begin
         if (c > lo) c = c - 1;
         else begin c = lo + 1; d = 1'b0; end
      end
   endfunction

   task automatic step_a(input bit en, input string tag);
      bus_a.enable = en;
      if (en) model_next(0, 31, ma_c, ma_d);
      exp_q.push_back(ma_c);
      @(posedge clk); #1;
      chk(tag, int'(bus_a.count), exp_q.pop_front());
   endtask

   task automatic step_b(input string tag);
      bus_b.enable = 1'b1;
      model_next(3, 6, mb_c, mb_d);
      exp_q.push_back(mb_c);
      @(posedge clk); #1;
      chk(tag, int'(bus_b.count), exp_q.pop_front());
   endtask

   initial begin
      reset_a      = 1'b0;
      reset_b      = 1'b0;
      bus_a.enable = 1'b1;
      bus_b.enable = 1'b0;

      // reset held with enable high
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_hold", int'(bus_a.count), 0);
      end
      chk("rst_b", int'(bus_b.count), 3);

      reset_a = 1'b1;
      repeat (5) step_a(1'b1, "pre_async");

      // asynchronous reset between edges
      #2 reset_a = 1'b0;
      #1 chk("async_rst", int'(bus_a.count), 0);
      ma_c = 0; ma_d = 1'b0;
      @(posedge clk); #1;
      chk("rst_edge", int'(bus_a.count), 0);
      reset_a = 1'b1;

      // full period: up to 31, down to 0, then 1
      repeat (31) step_a(1'b1, "sweep_up");
      chk("top", int'(bus_a.count), 31);
      repeat (31) step_a(1'b1, "sweep_dn");
      chk("bottom", int'(bus_a.count), 0);
      step_a(1'b1, "bounce_lo");

      // hold while UP
      repeat (6) step_a(1'b1, "to7");
      chk("at7", int'(bus_a.count), 7);
      repeat (3) step_a(1'b0, "hold_up");
      step_a(1'b1, "resume_up");

      // hold while DOWN
      repeat (23) step_a(1'b1, "to31");
      repeat (11) step_a(1'b1, "to20");
      chk("at20", int'(bus_a.count), 20);
      repeat (2) step_a(1'b0, "hold_dn");
      step_a(1'b1, "resume_dn");

      // reset while DOWN at 12
      repeat (7) step_a(1'b1, "to12");
      chk("at12", int'(bus_a.count), 12);
      #2 reset_a = 1'b0;
      #1 chk("rst_down", int'(bus_a.count), 0);
      ma_c = 0; ma_d = 1'b0;
      @(posedge clk); #1;
      reset_a = 1'b1;
      step_a(1'b1, "post_rst_up");

      // narrow instance 3..6
      reset_b = 1'b1;
      repeat (13) step_b("narrow");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
